// File: rtl/fp_pkg.sv
// fp_pkg: shared IEEE-754 constants, operand classes and the canonical qNaN helper.
package fp_pkg;
  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RDN = 2'd2;
  localparam logic [1:0] RM_RUP = 2'd3;
  localparam int FEX_NV = 3;
  localparam int FEX_OF = 2;
  localparam int FEX_UF = 1;
  localparam int FEX_NX = 0;
  typedef enum logic [2:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_QNAN, CLS_SNAN} fp_class_e;
  function automatic logic [63:0] canon_qnan(input int ew, input int mw);
    return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
  endfunction
endpackage

// File: rtl/fp_round.sv
// fp_round: combinational normalise/round/pack of a raw mantissa product with flush-to-zero.
module fp_round
  import fp_pkg::*;
#(
  parameter int EWIDTH = 8,
  parameter int MWIDTH = 23
) (
  input  logic                      sign_i,
  input  logic signed [EWIDTH+1:0]  exp_i,
  input  logic [2*MWIDTH+1:0]       prod_i,
  input  logic [1:0]                rm_i,
  output logic [EWIDTH+MWIDTH:0]    result_o,
  output logic [3:0]                fex_o
);
  localparam int XW = EWIDTH + 2;
  localparam logic [EWIDTH-1:0] EMAX = '1;
  localparam logic signed [XW-1:0] EMAXS = XW'((1 << EWIDTH) - 1);
  logic [2*MWIDTH:0] np;
  logic [MWIDTH-1:0] frac, frac_r;
  logic [MWIDTH+1:0] sum;
  logic g, s, inx, up, uf, ovf, to_inf;
  logic signed [XW-1:0] er;
  // left-align so the leading one sits just above the fraction field
  assign np = prod_i[2*MWIDTH+1] ? prod_i[2*MWIDTH:0] : {prod_i[2*MWIDTH-1:0], 1'b0};
  assign frac = np[2*MWIDTH -: MWIDTH];
  assign g = np[MWIDTH];
  assign s = |np[MWIDTH-1:0];
  assign inx = g | s;
  assign up = rm_i == RM_RNE ? g & (s | frac[0]) :
              rm_i == RM_RDN ? inx & sign_i :
              rm_i == RM_RUP ? inx & !sign_i : 1'b0;
  assign sum = {2'b01, frac} + (MWIDTH+2)'(up);
  assign frac_r = sum[MWIDTH+1] ? sum[MWIDTH:1] : sum[MWIDTH-1:0];
  assign er = exp_i + XW'(prod_i[2*MWIDTH+1]) + XW'(sum[MWIDTH+1]);
  assign uf = er <= 0;
  assign ovf = !uf && er >= EMAXS;
  assign to_inf = rm_i == RM_RNE || (rm_i == RM_RDN && sign_i) || (rm_i == RM_RUP && !sign_i);
  always_comb begin
    result_o = uf ? {sign_i, {(EWIDTH+MWIDTH){1'b0}}} :
               ovf ? (to_inf ? {sign_i, EMAX, {MWIDTH{1'b0}}} : {sign_i, EMAX - 1'b1, {MWIDTH{1'b1}}}) :
               {sign_i, er[EWIDTH-1:0], frac_r};
    fex_o = '0;
    fex_o[FEX_OF] = ovf;
    fex_o[FEX_UF] = uf;
    fex_o[FEX_NX] = uf | ovf | inx;
  end
endmodule

// File: rtl/fpmul_pipe.sv
// fpmul_pipe: 3-stage IEEE-754 multiplier with rounding modes, valid/ready flow control and tag pass-through.
module fpmul_pipe
  import fp_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int EWIDTH = 8,
  parameter int MWIDTH = 23,
  parameter int TWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  input  logic [1:0]        rm,
  input  logic [TWIDTH-1:0] tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] result,
  output logic [3:0]        fex,
  output logic [TWIDTH-1:0] tag_out
);
  localparam int PW = 2*MWIDTH + 2;
  localparam int XW = EWIDTH + 2;
  localparam logic [EWIDTH-1:0] EMAX = '1;
  localparam logic signed [XW-1:0] BIAS = XW'((1 << (EWIDTH-1)) - 1);
  localparam logic [63:0] QNAN64 = canon_qnan(EWIDTH, MWIDTH);
  localparam logic [DWIDTH-1:0] QNAN = QNAN64[DWIDTH-1:0];
  function automatic fp_class_e classify(input logic [DWIDTH-1:0] x);
    logic [EWIDTH-1:0] e;
    logic [MWIDTH-1:0] f;
    e = x[DWIDTH-2 -: EWIDTH];
    f = x[MWIDTH-1:0];
    return e == '0 ? CLS_ZERO : e != EMAX ? CLS_NORM : f == '0 ? CLS_INF :
           f[MWIDTH-1] ? CLS_QNAN : CLS_SNAN;
  endfunction
  fp_class_e ca, cb;
  logic adv, nan, zxi, inf, sign_d, sp1_d, nv1_d;
  logic [DWIDTH-1:0] spr1_d;
  logic signed [XW-1:0] e1_d;
  logic v1_q, s1_q, sp1_q, nv1_q, v2_q, s2_q, sp2_q, nv2_q, v3_q;
  logic signed [XW-1:0] e1_q, e2_q;
  logic [MWIDTH:0] ma1_q, mb1_q;
  logic [1:0] rm1_q, rm2_q;
  logic [TWIDTH-1:0] tag1_q, tag2_q, tag3_q, tag3_d;
  logic [DWIDTH-1:0] spr1_q, spr2_q, res3_q, res3_d, rnd_res;
  logic [PW-1:0] prod2_d, prod2_q;
  logic [3:0] fex3_q, fex3_d, rnd_fex;
  assign adv = !v3_q || out_ready;
  assign in_ready = adv;
  assign ca = classify(a);
  assign cb = classify(b);
  assign nan = ca inside {CLS_QNAN, CLS_SNAN} || cb inside {CLS_QNAN, CLS_SNAN};
  assign zxi = (ca == CLS_ZERO && cb == CLS_INF) || (ca == CLS_INF && cb == CLS_ZERO);
  assign inf = ca == CLS_INF || cb == CLS_INF;
  assign sign_d = a[DWIDTH-1] ^ b[DWIDTH-1];
  assign sp1_d = !(ca == CLS_NORM && cb == CLS_NORM);
  assign nv1_d = ca == CLS_SNAN || cb == CLS_SNAN || zxi;
  // specials are resolved up front and bypass the rounder in S3
  assign spr1_d = nan || zxi ? QNAN :
                  inf ? {sign_d, EMAX, {MWIDTH{1'b0}}} : {sign_d, {(DWIDTH-1){1'b0}}};
  assign e1_d = $signed({2'b00, a[DWIDTH-2 -: EWIDTH]}) + $signed({2'b00, b[DWIDTH-2 -: EWIDTH]}) - BIAS;
  assign prod2_d = PW'(ma1_q) * PW'(mb1_q);
  fp_round #(.EWIDTH(EWIDTH), .MWIDTH(MWIDTH)) u_round (
    .sign_i(s2_q), .exp_i(e2_q), .prod_i(prod2_q), .rm_i(rm2_q),
    .result_o(rnd_res), .fex_o(rnd_fex)
  );
  assign res3_d = !v2_q ? '0 : sp2_q ? spr2_q : rnd_res;
  assign fex3_d = !v2_q ? '0 : sp2_q ? {nv2_q, 3'b000} : rnd_fex;
  assign tag3_d = v2_q ? tag2_q : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      {v1_q, s1_q, sp1_q, nv1_q, v2_q, s2_q, sp2_q, nv2_q, v3_q} <= '0;
      {e1_q, e2_q, ma1_q, mb1_q, rm1_q, rm2_q} <= '0;
      {tag1_q, tag2_q, tag3_q, spr1_q, spr2_q, res3_q, prod2_q, fex3_q} <= '0;
    end else if (adv) begin
      v1_q <= in_valid;
      s1_q <= sign_d;
      e1_q <= e1_d;
      ma1_q <= {1'b1, a[MWIDTH-1:0]};
      mb1_q <= {1'b1, b[MWIDTH-1:0]};
      rm1_q <= rm;
      tag1_q <= tag_in;
      sp1_q <= sp1_d;
      spr1_q <= spr1_d;
      nv1_q <= nv1_d;
      v2_q <= v1_q;
      s2_q <= s1_q;
      e2_q <= e1_q;
      prod2_q <= prod2_d;
      rm2_q <= rm1_q;
      tag2_q <= tag1_q;
      sp2_q <= sp1_q;
      spr2_q <= spr1_q;
      nv2_q <= nv1_q;
      v3_q <= v2_q;
      res3_q <= res3_d;
      fex3_q <= fex3_d;
      tag3_q <= tag3_d;
    end
  end
  assign out_valid = v3_q;
  assign result = res3_q;
  assign fex = fex3_q;
  assign tag_out = tag3_q;
endmodule

// File: tb/tb_fpmul_pipe.sv
// tb_fpmul_pipe: directed self-checking bench for fpmul_pipe (binary32 configuration).
module tb_fpmul_pipe;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [31:0] a = 0, b = 0, result;
  logic [1:0] rm = 0;
  logic [4:0] tag_in = 0, tag_out;
  logic [3:0] fex;
  int n_tests = 0, n_fail = 0;

  fpmul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .rm(rm), .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .fex(fex), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] irm,
                        input logic [4:0] itag, output logic [31:0] r, output logic [3:0] f,
                        output logic [4:0] t, output logic seen);
    a = ia; b = ib; rm = irm; tag_in = itag; in_valid = 1; out_ready = 1;
    @(posedge clk);
    #1 in_valid = 0;
    seen = 0; r = '0; f = '0; t = '0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1; r = result; f = fex; t = tag_out;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1; in_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    n_tests++;
    if ({out_valid, result, fex, tag_out, in_ready} !== {1'b0, 32'h0, 4'h0, 5'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: got v=%b r=%h f=%b t=%0d ir=%b, want v=0 r=0 f=0 t=0 ir=1",
               out_valid, result, fex, tag_out, in_ready);
    end
  endtask

  task automatic test_latency;
    @(posedge clk);
    #1 a = 32'h3F800000; b = 32'h40000000; rm = 2'd0; tag_in = 5; in_valid = 1; out_ready = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(posedge clk);
    #1 n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_early: out_valid=%b after 2 edges, want 0", out_valid);
    end
    @(posedge clk);
    #1 n_tests++;
    if ({out_valid, result, fex, tag_out} !== {1'b1, 32'h40000000, 4'b0000, 5'd5}) begin
      n_fail++;
      $display("FAIL latency: got v=%b r=%h f=%b t=%0d, want v=1 r=40000000 f=0000 t=5",
               out_valid, result, fex, tag_out);
    end
    @(negedge clk);
  endtask

  task automatic test_rounding;
    logic [31:0] exp_r[4] = '{32'h3FA3D70B, 32'h3FA3D70A, 32'h3FA3D70A, 32'h3FA3D70B};
    logic [31:0] r; logic [3:0] f; logic [4:0] t; logic seen;
    for (int i = 0; i < 4; i++) begin
      run_op(32'h3FCCCCCD, 32'h3F4CCCCD, 2'(i), 5'(10 + i), r, f, t, seen);
      n_tests++;
      if (!seen || r !== exp_r[i] || f !== 4'b0001 || t !== 5'(10 + i)) begin
        n_fail++;
        $display("FAIL round rm=%0d: got seen=%b r=%h f=%b t=%0d, want r=%h f=0001 t=%0d",
                 i, seen, r, f, t, exp_r[i], 10 + i);
      end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] va[4] = '{32'h7F000000, 32'h7F000000, 32'hFF000000, 32'hFF000000};
    logic [1:0]  vm[4] = '{2'd0, 2'd1, 2'd3, 2'd2};
    logic [31:0] vr[4] = '{32'h7F800000, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'hFF800000};
    logic [31:0] r; logic [3:0] f; logic [4:0] t; logic seen;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], 32'h40000000, vm[i], 5'(i), r, f, t, seen);
      n_tests++;
      if (!seen || r !== vr[i] || f !== 4'b0101) begin
        n_fail++;
        $display("FAIL overflow #%0d: got seen=%b r=%h f=%b, want r=%h f=0101", i, seen, r, f, vr[i]);
      end
    end
  endtask

  task automatic test_specials;
    logic [31:0] va[6] = '{32'h00000000, 32'h7FC00001, 32'h7F800001, 32'hFF800000, 32'h80000000, 32'h7F800000};
    logic [31:0] vb[6] = '{32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h80000000};
    logic [31:0] vr[6] = '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h7FC00000};
    logic [3:0]  vf[6] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b1000};
    logic [31:0] r; logic [3:0] f; logic [4:0] t; logic seen;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], 2'd0, 5'(20 + i), r, f, t, seen);
      n_tests++;
      if (!seen || r !== vr[i] || f !== vf[i] || t !== 5'(20 + i)) begin
        n_fail++;
        $display("FAIL special #%0d: got seen=%b r=%h f=%b t=%0d, want r=%h f=%b t=%0d",
                 i, seen, r, f, t, vr[i], vf[i], 20 + i);
      end
    end
  endtask

  task automatic test_underflow;
    logic [31:0] va[3] = '{32'h00800000, 32'h80400000, 32'h80800000};
    logic [31:0] vb[3] = '{32'h3F000000, 32'h40000000, 32'h3F000000};
    logic [31:0] vr[3] = '{32'h00000000, 32'h80000000, 32'h80000000};
    logic [3:0]  vf[3] = '{4'b0011, 4'b0000, 4'b0011};
    logic [31:0] r; logic [3:0] f; logic [4:0] t; logic seen;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 2'd0, 5'(i), r, f, t, seen);
      n_tests++;
      if (!seen || r !== vr[i] || f !== vf[i]) begin
        n_fail++;
        $display("FAIL underflow #%0d: got seen=%b r=%h f=%b, want r=%h f=%b", i, seen, r, f, vr[i], vf[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int k = 0, got = 0;
    logic ir, ov;
    logic [4:0] t;
    logic [31:0] r;
    @(posedge clk);
    #1;
    for (int c = 0; c < 40 && got < 5; c++) begin
      out_ready = c >= 6;
      in_valid = k < 5; tag_in = 5'(k); rm = 2'd0;
      a = 32'h3F800000 | (32'(k) << 20); b = 32'h40000000;
      @(negedge clk);
      ir = in_ready; ov = out_valid; t = tag_out; r = result;
      if (c >= 3 && c < 6) begin
        n_tests++;
        if (ir !== 1'b0 || ov !== 1'b1 || t !== 5'd0 || r !== 32'h40000000 || k != 3) begin
          n_fail++;
          $display("FAIL stall c=%0d: got ir=%b v=%b t=%0d r=%h accepts=%0d, want ir=0 v=1 t=0 r=40000000 accepts=3",
                   c, ir, ov, t, r, k);
        end
      end
      if (ov && out_ready) begin
        n_tests++;
        if (t !== 5'(got) || r !== (32'h40000000 | (32'(got) << 20))) begin
          n_fail++;
          $display("FAIL order #%0d: got t=%0d r=%h, want t=%0d r=%h", got, t, r, got,
                   32'h40000000 | (32'(got) << 20));
        end
        got++;
      end
      @(posedge clk);
      #1;
      if (in_valid && ir) k++;
    end
    in_valid = 0;
    n_tests++;
    if (got != 5 || k != 5) begin
      n_fail++; $display("FAIL bp_count: got %0d results %0d accepts, want 5 and 5", got, k);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r; logic [3:0] f; logic [4:0] t; logic seen;
    int stray = 0;
    @(posedge clk);
    #1 out_ready = 0; in_valid = 1; a = 32'h3FCCCCCD; b = 32'h3F4CCCCD; tag_in = 7;
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0; in_valid = 0; out_ready = 1;
    @(negedge clk);
    n_tests++;
    if ({out_valid, result, fex, tag_out, in_ready} !== {1'b0, 32'h0, 4'h0, 5'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b r=%h f=%b t=%0d ir=%b, want v=0 r=0 f=0 t=0 ir=1",
               out_valid, result, fex, tag_out, in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    n_tests++;
    if (stray != 0) begin
      n_fail++; $display("FAIL reset_flush: %0d stale results after reset, want 0", stray);
    end
    run_op(32'h40400000, 32'h40000000, 2'd0, 5'd3, r, f, t, seen);
    n_tests++;
    if (!seen || r !== 32'h40C00000 || f !== 4'b0000 || t !== 5'd3) begin
      n_fail++;
      $display("FAIL post_reset: got seen=%b r=%h f=%b t=%0d, want r=40c00000 f=0000 t=3", seen, r, f, t);
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_rounding;
    test_overflow;
    test_specials;
    test_underflow;
    test_backpressure;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
